// File: rtl/plic_claim_scheduler.sv
// plic_claim_scheduler: per-target PLIC arbitration. Serially scans sources
// 1..SOURCES (one per cycle) for the highest-priority enabled pending source,
// commits the winner to id_o/ireq_o, and services claim/complete strobes.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   ip_i, ie_i            per-source pending flags and enables (bit n-1 = ID n)
//   priority_i            packed per-source priorities (ID n at slice n-1)
//   threshold_i           target threshold; ireq_o needs priority > threshold
//   claim_i               claim strobe; clears id_o/ireq_o and restarts the scan
//   complete_i,
//   complete_id_i         completion strobe and the ID being completed
//   id_o, ireq_o          registered claim value and interrupt request
//   claimed_o             one-cycle one-hot pulse of the claimed source
//   completed_o           one-cycle one-hot pulse of the completed source
module plic_claim_scheduler #(
    parameter int unsigned SOURCES       = 8,
    parameter int unsigned PRIORITIES    = 7,
    parameter int unsigned SOURCES_BITS  = $clog2(SOURCES + 1),
    parameter int unsigned PRIORITY_BITS = $clog2(PRIORITIES)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [SOURCES-1:0]                 ip_i,
    input  logic [SOURCES-1:0]                 ie_i,
    input  logic [SOURCES*PRIORITY_BITS-1:0]   priority_i,
    input  logic [PRIORITY_BITS-1:0]           threshold_i,
    input  logic                               claim_i,
    input  logic                               complete_i,
    input  logic [SOURCES_BITS-1:0]            complete_id_i,
    output logic [SOURCES_BITS-1:0]            id_o,
    output logic                               ireq_o,
    output logic [SOURCES-1:0]                 claimed_o,
    output logic [SOURCES-1:0]                 completed_o
);

    typedef enum logic [0:0] {
        SCAN   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    state_t                   state;
    logic [SOURCES_BITS-1:0]  idx;
    logic [SOURCES_BITS-1:0]  best_id;
    logic [PRIORITY_BITS-1:0] best_prio;

    logic                     cur_cand;
    logic [PRIORITY_BITS-1:0] cur_prio;
    logic [SOURCES-1:0]       claim_hot;
    logic [SOURCES-1:0]       complete_hot;

    // Candidate status and priority of the source at the scan index.
    always_comb begin
        cur_cand = 1'b0;
        cur_prio = '0;
        for (int unsigned n = 0; n < SOURCES; n++) begin
            if (idx == SOURCES_BITS'(n + 1)) begin
                cur_prio = priority_i[n*PRIORITY_BITS +: PRIORITY_BITS];
                cur_cand = ip_i[n] && ie_i[n] && (cur_prio != '0);
            end
        end
    end

    // One-hot decodes; IDs of 0 or above SOURCES match no bit.
    always_comb begin
        claim_hot    = '0;
        complete_hot = '0;
        for (int unsigned n = 0; n < SOURCES; n++) begin
            claim_hot[n]    = (id_o == SOURCES_BITS'(n + 1));
            complete_hot[n] = (complete_id_i == SOURCES_BITS'(n + 1));
        end
    end

    // Scan/commit FSM with registered outputs; a claim overrides any commit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= SCAN;
            idx         <= SOURCES_BITS'(1);
            best_id     <= '0;
            best_prio   <= '0;
            id_o        <= '0;
            ireq_o      <= 1'b0;
            claimed_o   <= '0;
            completed_o <= '0;
        end else begin
            claimed_o   <= claim_i    ? claim_hot    : '0;
            completed_o <= complete_i ? complete_hot : '0;

            if (claim_i) begin
                id_o      <= '0;
                ireq_o    <= 1'b0;
                best_id   <= '0;
                best_prio <= '0;
                idx       <= SOURCES_BITS'(1);
                state     <= SCAN;
            end else begin
                case (state)
                    SCAN: begin
                        // Strictly greater: ties keep the lower ID already stored.
                        if (cur_cand && (cur_prio > best_prio)) begin
                            best_id   <= idx;
                            best_prio <= cur_prio;
                        end
                        if (idx == SOURCES_BITS'(SOURCES)) begin
                            state <= COMMIT;
                        end else begin
                            idx <= idx + SOURCES_BITS'(1);
                        end
                    end
                    COMMIT: begin
                        id_o      <= best_id;
                        ireq_o    <= (best_prio > threshold_i);
                        best_id   <= '0;
                        best_prio <= '0;
                        idx       <= SOURCES_BITS'(1);
                        state     <= SCAN;
                    end
                    default: begin
                        state <= SCAN;
                        idx   <= SOURCES_BITS'(1);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_plic_claim_scheduler.sv
// Directed testbench for plic_claim_scheduler (SOURCES=8, PRIORITIES=7).
module tb_plic_claim_scheduler;

    localparam int unsigned SOURCES = 8;
    localparam int unsigned SB      = 4;
    localparam int unsigned PB      = 3;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [SOURCES-1:0] ip_i;
    logic [SOURCES-1:0] ie_i;
    logic [SOURCES*PB-1:0] priority_i;
    logic [PB-1:0]     threshold_i;
    logic              claim_i;
    logic              complete_i;
    logic [SB-1:0]     complete_id_i;
    logic [SB-1:0]     id_o;
    logic              ireq_o;
    logic [SOURCES-1:0] claimed_o;
    logic [SOURCES-1:0] completed_o;

    int checks = 0;
    int errors = 0;

    plic_claim_scheduler #(
        .SOURCES    (8),
        .PRIORITIES (7)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ip_i          (ip_i),
        .ie_i          (ie_i),
        .priority_i    (priority_i),
        .threshold_i   (threshold_i),
        .claim_i       (claim_i),
        .complete_i    (complete_i),
        .complete_id_i (complete_id_i),
        .id_o          (id_o),
        .ireq_o        (ireq_o),
        .claimed_o     (claimed_o),
        .completed_o   (completed_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one active edge, then settle 1ns so outputs are sampled off-edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_prio(input int id, input int val);
        priority_i[(id-1)*PB +: PB] = PB'(val);
    endtask

    task automatic clear_inputs();
        ip_i          = '0;
        ie_i          = '0;
        priority_i    = '0;
        threshold_i   = '0;
        claim_i       = 1'b0;
        complete_i    = 1'b0;
        complete_id_i = '0;
    endtask

    // One reset edge, then release; commits land 9 edges after this returns.
    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        // Claim and complete during reset must be ignored.
        claim_i       = 1'b1;
        complete_i    = 1'b1;
        complete_id_i = 4'd3;
        tick();
        checks++;
        if (id_o !== 4'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", id_o); end
        checks++;
        if (ireq_o !== 1'b0) begin errors++; $display("FAIL reset_ireq: got %0b expected 0", ireq_o); end
        checks++;
        if (claimed_o !== 8'h00 || completed_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_pulses: got claimed=%h completed=%h expected 00/00", claimed_o, completed_o);
        end
        claim_i    = 1'b0;
        complete_i = 1'b0;
        rst_i      = 1'b0;
        tick();
        checks++;
        if (claimed_o !== 8'h00 || completed_o !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_pulses: got claimed=%h completed=%h expected 00/00", claimed_o, completed_o);
        end
    endtask

    task automatic test_single();
        clear_inputs();
        // ID3 is the only true candidate; ID1 disabled, ID8 has priority 0.
        ip_i = 8'h85;
        ie_i = 8'h84;
        set_prio(3, 5);
        set_prio(1, 7);
        set_prio(8, 0);
        threshold_i = 3'd2;
        do_reset();
        run(8);
        checks++;
        if (id_o !== 4'd0) begin errors++; $display("FAIL single_early: got %0d expected 0", id_o); end
        tick();
        checks++;
        if (id_o !== 4'd3 || ireq_o !== 1'b1) begin
            errors++;
            $display("FAIL single_commit: got id=%0d ireq=%0b expected 3/1", id_o, ireq_o);
        end
        claim_i = 1'b1;
        ip_i    = 8'h00;
        tick();
        claim_i = 1'b0;
        checks++;
        if (claimed_o !== 8'h04 || id_o !== 4'd0 || ireq_o !== 1'b0) begin
            errors++;
            $display("FAIL single_claim: got claimed=%h id=%0d ireq=%0b expected 04/0/0", claimed_o, id_o, ireq_o);
        end
        tick();
        checks++;
        if (claimed_o !== 8'h00) begin errors++; $display("FAIL single_pulse_width: got %h expected 00", claimed_o); end
    endtask

    task automatic test_tie_threshold();
        clear_inputs();
        ip_i = 8'h22;
        ie_i = 8'h22;
        set_prio(2, 4);
        set_prio(6, 4);
        threshold_i = 3'd4;
        do_reset();
        run(9);
        checks++;
        if (id_o !== 4'd2 || ireq_o !== 1'b0) begin
            errors++;
            $display("FAIL tie_thr4: got id=%0d ireq=%0b expected 2/0", id_o, ireq_o);
        end
        threshold_i = 3'd3;
        run(9);
        checks++;
        if (id_o !== 4'd2 || ireq_o !== 1'b1) begin
            errors++;
            $display("FAIL tie_thr3: got id=%0d ireq=%0b expected 2/1", id_o, ireq_o);
        end
        set_prio(6, 6);
        run(9);
        checks++;
        if (id_o !== 4'd6 || ireq_o !== 1'b1) begin
            errors++;
            $display("FAIL higher_id_wins: got id=%0d ireq=%0b expected 6/1", id_o, ireq_o);
        end
    endtask

    task automatic test_claim_abort();
        clear_inputs();
        ip_i = 8'h04;
        ie_i = 8'h04;
        set_prio(3, 5);
        threshold_i = 3'd2;
        do_reset();
        run(4);
        claim_i = 1'b1;
        tick();
        claim_i = 1'b0;
        checks++;
        if (claimed_o !== 8'h00) begin errors++; $display("FAIL abort_no_pulse: got %h expected 00", claimed_o); end
        run(4);
        checks++;
        if (id_o !== 4'd0) begin errors++; $display("FAIL abort_old_commit: got %0d expected 0", id_o); end
        run(4);
        checks++;
        if (id_o !== 4'd0) begin errors++; $display("FAIL abort_early: got %0d expected 0", id_o); end
        tick();
        checks++;
        if (id_o !== 4'd3 || ireq_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_commit: got id=%0d ireq=%0b expected 3/1", id_o, ireq_o);
        end
    endtask

    task automatic test_claim_at_commit();
        clear_inputs();
        ip_i = 8'h04;
        ie_i = 8'h04;
        set_prio(3, 5);
        threshold_i = 3'd2;
        do_reset();
        run(8);
        // This edge would commit ID3; the claim discards it.
        claim_i = 1'b1;
        tick();
        claim_i = 1'b0;
        checks++;
        if (id_o !== 4'd0 || claimed_o !== 8'h00) begin
            errors++;
            $display("FAIL claim_commit_zero: got id=%0d claimed=%h expected 0/00", id_o, claimed_o);
        end
        run(9);
        checks++;
        if (id_o !== 4'd3) begin errors++; $display("FAIL claim_commit_rescan: got %0d expected 3", id_o); end
        run(8);
        claim_i = 1'b1;
        tick();
        claim_i = 1'b0;
        checks++;
        if (id_o !== 4'd0 || claimed_o !== 8'h04) begin
            errors++;
            $display("FAIL claim_commit_preid: got id=%0d claimed=%h expected 0/04", id_o, claimed_o);
        end
    endtask

    task automatic test_complete();
        clear_inputs();
        do_reset();
        complete_i    = 1'b1;
        complete_id_i = 4'd5;
        tick();
        complete_i = 1'b0;
        checks++;
        if (completed_o !== 8'h10) begin errors++; $display("FAIL complete_5: got %h expected 10", completed_o); end
        tick();
        checks++;
        if (completed_o !== 8'h00) begin errors++; $display("FAIL complete_width: got %h expected 00", completed_o); end
        complete_i    = 1'b1;
        complete_id_i = 4'd0;
        tick();
        checks++;
        if (completed_o !== 8'h00) begin errors++; $display("FAIL complete_0: got %h expected 00", completed_o); end
        complete_id_i = 4'd9;
        tick();
        complete_i = 1'b0;
        checks++;
        if (completed_o !== 8'h00) begin errors++; $display("FAIL complete_9: got %h expected 00", completed_o); end
        complete_i    = 1'b1;
        complete_id_i = 4'd8;
        tick();
        complete_i = 1'b0;
        checks++;
        if (completed_o !== 8'h80) begin errors++; $display("FAIL complete_8: got %h expected 80", completed_o); end
    endtask

    task automatic test_simultaneous();
        clear_inputs();
        ip_i = 8'h40;
        ie_i = 8'h40;
        set_prio(7, 3);
        do_reset();
        run(9);
        checks++;
        if (id_o !== 4'd7 || ireq_o !== 1'b1) begin
            errors++;
            $display("FAIL simul_commit: got id=%0d ireq=%0b expected 7/1", id_o, ireq_o);
        end
        claim_i       = 1'b1;
        complete_i    = 1'b1;
        complete_id_i = 4'd1;
        tick();
        claim_i    = 1'b0;
        complete_i = 1'b0;
        checks++;
        if (claimed_o !== 8'h40 || completed_o !== 8'h01 || id_o !== 4'd0) begin
            errors++;
            $display("FAIL simul_pulses: got claimed=%h completed=%h id=%0d expected 40/01/0",
                     claimed_o, completed_o, id_o);
        end
    endtask

    task automatic test_reset_mid_scan();
        clear_inputs();
        ip_i = 8'h04;
        ie_i = 8'h04;
        set_prio(3, 5);
        threshold_i = 3'd2;
        do_reset();
        run(9);
        checks++;
        if (ireq_o !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %0b expected 1", ireq_o); end
        run(3);
        rst_i = 1'b1;
        tick();
        checks++;
        if (id_o !== 4'd0 || ireq_o !== 1'b0 || claimed_o !== 8'h00 || completed_o !== 8'h00) begin
            errors++;
            $display("FAIL rmid_clear: got id=%0d ireq=%0b claimed=%h completed=%h expected all 0",
                     id_o, ireq_o, claimed_o, completed_o);
        end
        rst_i = 1'b0;
        run(8);
        checks++;
        if (id_o !== 4'd0) begin errors++; $display("FAIL rmid_early: got %0d expected 0", id_o); end
        tick();
        checks++;
        if (id_o !== 4'd3 || ireq_o !== 1'b1) begin
            errors++;
            $display("FAIL rmid_commit: got id=%0d ireq=%0b expected 3/1", id_o, ireq_o);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        #2;
        test_reset();
        test_single();
        test_tie_threshold();
        test_claim_abort();
        test_claim_at_commit();
        test_complete();
        test_simultaneous();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/plic_claim_scheduler.md
PLIC_CLAIM_SCHEDULER -- requirements
Module: plic_claim_scheduler

Interface
REQ-001 Parameter SOURCES, default 8, number of interrupt sources; IDs are 1..SOURCES and ID 0 means none.
REQ-002 Parameter PRIORITIES, default 7, number of priority levels.
REQ-003 Parameter SOURCES_BITS, default $clog2(SOURCES+1), ID width.
REQ-004 Parameter PRIORITY_BITS, default $clog2(PRIORITIES), priority width.
REQ-005 Port clk_i, input, 1 bit, system clock; the only clock.
REQ-006 Port rst_i, input, 1 bit, synchronous active-high reset.
REQ-007 Port ip_i, input, SOURCES bits, pending flag per source; bit n-1 belongs to ID n.
REQ-008 Port ie_i, input, SOURCES bits, per-source enable for this target.
REQ-009 Port priority_i, input, SOURCES*PRIORITY_BITS bits, packed priorities; ID n occupies bits [n*PRIORITY_BITS-1 : (n-1)*PRIORITY_BITS].
REQ-010 Port threshold_i, input, PRIORITY_BITS bits, target priority threshold.
REQ-011 Port claim_i, input, 1 bit, single-cycle claim strobe.
REQ-012 Port complete_i, input, 1 bit, single-cycle completion strobe.
REQ-013 Port complete_id_i, input, SOURCES_BITS bits, ID being completed.
REQ-014 Port id_o, output, SOURCES_BITS bits, registered highest-priority pending ID, which is the claim read value.
REQ-015 Port ireq_o, output, 1 bit, registered interrupt request to the target.
REQ-016 Port claimed_o, output, SOURCES bits, one-hot single-cycle pulse telling the gateway to clear the pending flag.
REQ-017 Port completed_o, output, SOURCES bits, one-hot single-cycle completion pulse to the gateway.

Function
REQ-018 A source is a candidate when ip_i, ie_i and priority>0 all hold for that source.
REQ-019 FSM states are SCAN and COMMIT; the scan index idx is SOURCES_BITS wide.
REQ-020 In SCAN, the block examines one source per cycle, starting at idx=1 and ending at idx=SOURCES.
REQ-021 In SCAN, the best-candidate register is replaced only when the examined candidate has a priority strictly greater than the stored best, so ties go to the lower ID.
REQ-022 When idx=SOURCES is examined, the FSM goes to COMMIT on the next cycle.
REQ-023 In COMMIT, id_o is loaded with the best ID, or 0 if there is no candidate.
REQ-024 In COMMIT, ireq_o is loaded with (best priority > threshold_i), using threshold_i as sampled in that cycle.
REQ-025 In COMMIT, the best registers are cleared, idx is set to 1 and the FSM returns to SCAN, so the full period is SOURCES+1 cycles.
REQ-026 id_o and ireq_o change only in COMMIT, on claim, or on reset.
REQ-027 On claim_i with id_o=k≠0, the next cycle has claimed_o bit k-1 =1 for exactly one cycle.
REQ-028 On claim_i with id_o=k≠0, id_o and ireq_o go to 0 in the next cycle.
REQ-029 On claim_i with id_o=k≠0, the FSM restarts SCAN at idx=1 with the best registers cleared, aborting any scan in progress.
REQ-030 On claim_i with id_o=0, claimed_o stays 0, but the scan still restarts.
REQ-031 A claim that coincides with COMMIT takes priority: the commit is discarded and the claim uses the pre-commit id_o.
REQ-032 On complete_i with 1 ≤ complete_id_i ≤ SOURCES, completed_o bit complete_id_i-1 pulses for one cycle on the next cycle.
REQ-033 A complete_i with complete_id_i of 0 or greater than SOURCES is ignored, and completed_o stays 0.
REQ-034 Completion does not affect the FSM, id_o or ireq_o.
REQ-035 Simultaneous claim_i and complete_i are both serviced independently in the same cycle.
REQ-036 Inputs that change mid-scan are not re-evaluated for indices already passed; they are picked up by the next scan.

Reset
REQ-037 While rst_i=1 at a clock edge: id_o=0, ireq_o=0, claimed_o=0, completed_o=0, best registers=0, idx=1, state=SCAN.
REQ-038 Reset overrides claim and complete, and no pulse may be emitted in the cycle after reset.
REQ-039 The first commit after reset release occurs SOURCES+1 cycles later.

Verification
REQ-040 Single source: SOURCES=8; ip=ie=8'h04 (ID3), prio3=5, threshold=2 -> within 9 cycles id_o=3 and ireq_o=1; claim -> next cycle claimed_o=8'h04, id_o=0, ireq_o=0.
REQ-041 Tie and threshold: IDs 2 and 6 both prio 4, threshold 4 -> id_o=2, ireq_o=0; then threshold 3 -> next commit gives ireq_o=1.
REQ-042 Claim abort: claim while id_o=0 mid-scan -> no claimed_o pulse; the next commit comes exactly 9 cycles after the claim cycle.
REQ-043 Completion bounds: complete_id 5 -> completed_o=8'h10 for one cycle; complete_id 0 or 9 -> completed_o=0.
REQ-044 Simultaneous events: claim with id_o=7 together with complete_id=1 -> claimed_o=8'h40 and completed_o=8'h01 in the same cycle.
REQ-045 Reset mid-scan: assert rst_i with ireq_o=1 -> next edge gives all outputs 0; release -> first commit after 9 cycles.
